// File: rtl/pipelined_main_memory.sv
// Unified instruction/data word memory with a read-only fetch port, a load/store data port,
// a configurable response latency and an optional post-reset zeroing sweep.
module pipelined_main_memory #(
    parameter int unsigned WORDS          = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned LATENCY        = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_instr,
    output logic        o_imem_fault,
    input  logic        i_dmem_req,
    input  logic        i_dmem_we,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [1:0]  i_dmem_wr_type,
    input  logic [2:0]  i_dmem_rd_type,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_fault
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } resp_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] clr_idx;
    logic             ready;
    logic             clr_we;

    logic [31:0]      mem [WORDS];

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        clr_we   = 1'b0;
        case (state)
            ST_RESET: state_nx = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            ST_INIT: begin
                clr_we = 1'b1;
                if (clr_idx == IDX_W'(WORDS - 1)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN:   ready = 1'b1;
            default:  state_nx = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_idx <= '0;
        end else if (clr_we) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    assign o_imem_ready = ready;
    assign o_dmem_ready = ready;

    // ---------------- fetch decode ----------------
    logic             imem_acc;
    logic [32:0]      i_diff;
    logic [IDX_W-1:0] i_idx;
    logic             i_fault;
    resp_t            i_stage0;

    always_comb begin
        imem_acc = i_imem_req && ready && rst;
        // 33-bit difference: a borrow lands in bit 32 and so counts as out of range
        i_diff   = {1'b0, i_imem_addr} - {1'b0, BASE_ADDR};
        i_idx    = i_diff[IDX_W+1:2];
        i_fault  = ((i_diff >> (IDX_W + 2)) != '0) || (i_imem_addr[1:0] != 2'b00);
        i_stage0.valid = imem_acc;
        i_stage0.fault = imem_acc && i_fault;
        i_stage0.data  = (imem_acc && !i_fault) ? mem[i_idx] : '0;
    end

    // ---------------- data decode ----------------
    logic             dmem_acc;
    logic [32:0]      d_diff;
    logic [IDX_W-1:0] d_idx;
    logic             d_oor;
    logic             d_illegal;
    logic             d_misal;
    logic             d_fault;
    logic [3:0]       d_be;
    logic [31:0]      d_wbytes;
    logic [31:0]      d_word;
    logic [7:0]       d_byte;
    logic [15:0]      d_half;
    logic [31:0]      d_ldata;
    resp_t            d_stage0;

    always_comb begin
        dmem_acc  = i_dmem_req && ready && rst;
        d_diff    = {1'b0, i_dmem_addr} - {1'b0, BASE_ADDR};
        d_idx     = d_diff[IDX_W+1:2];
        d_oor     = (d_diff >> (IDX_W + 2)) != '0;
        d_illegal = i_dmem_we ? (i_dmem_wr_type == 2'b00) : (i_dmem_rd_type > 3'd4);
        d_misal   = 1'b0;
        if (i_dmem_we) begin
            case (i_dmem_wr_type)
                2'b10:   d_misal = i_dmem_addr[0];
                2'b11:   d_misal = i_dmem_addr[1:0] != 2'b00;
                default: d_misal = 1'b0;
            endcase
        end else begin
            case (i_dmem_rd_type)
                3'd0:       d_misal = i_dmem_addr[1:0] != 2'b00;
                3'd2, 3'd4: d_misal = i_dmem_addr[0];
                default:    d_misal = 1'b0;
            endcase
        end
        d_fault = d_oor || d_illegal || d_misal;

        d_be     = 4'b0000;
        d_wbytes = '0;
        case (i_dmem_wr_type)
            2'b01: begin
                d_be     = 4'b0001 << i_dmem_addr[1:0];
                d_wbytes = {4{i_dmem_wdata[7:0]}};
            end
            2'b10: begin
                d_be     = i_dmem_addr[1] ? 4'b1100 : 4'b0011;
                d_wbytes = {2{i_dmem_wdata[15:0]}};
            end
            2'b11: begin
                d_be     = 4'b1111;
                d_wbytes = i_dmem_wdata;
            end
            default: begin
                d_be     = 4'b0000;
                d_wbytes = '0;
            end
        endcase

        d_word = mem[d_idx];
        case (i_dmem_addr[1:0])
            2'd0:    d_byte = d_word[7:0];
            2'd1:    d_byte = d_word[15:8];
            2'd2:    d_byte = d_word[23:16];
            default: d_byte = d_word[31:24];
        endcase
        d_half = i_dmem_addr[1] ? d_word[31:16] : d_word[15:0];
        case (i_dmem_rd_type)
            3'd0:    d_ldata = d_word;
            3'd1:    d_ldata = {{24{d_byte[7]}}, d_byte};
            3'd2:    d_ldata = {{16{d_half[15]}}, d_half};
            3'd3:    d_ldata = {24'd0, d_byte};
            3'd4:    d_ldata = {16'd0, d_half};
            default: d_ldata = '0;
        endcase

        d_stage0.valid = dmem_acc;
        d_stage0.fault = dmem_acc && d_fault;
        d_stage0.data  = (dmem_acc && !i_dmem_we && !d_fault) ? d_ldata : '0;
    end

    // ---------------- array ----------------
    always_ff @(posedge clk) begin
        if (rst && clr_we) begin
            mem[clr_idx] <= '0;
        end else if (dmem_acc && i_dmem_we && !d_fault) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (d_be[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wbytes[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response pipelines ----------------
    // Stage 0 captures the array read at the accept edge, so the output stage
    // LATENCY is presented right after edge T+LATENCY.
    resp_t ipipe [LATENCY+1];
    resp_t dpipe [LATENCY+1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                ipipe[i] <= '0;
                dpipe[i] <= '0;
            end
        end else begin
            ipipe[0] <= i_stage0;
            dpipe[0] <= d_stage0;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                ipipe[i] <= ipipe[i-1];
                dpipe[i] <= dpipe[i-1];
            end
        end
    end

    assign o_imem_valid = ipipe[LATENCY].valid;
    assign o_imem_fault = ipipe[LATENCY].fault;
    assign o_imem_instr = ipipe[LATENCY].data;
    assign o_dmem_valid = dpipe[LATENCY].valid;
    assign o_dmem_fault = dpipe[LATENCY].fault;
    assign o_dmem_rdata = dpipe[LATENCY].data;

endmodule
